n64_host_poller: RTL and testbench



---
 rtl/n64_host_poller_pkg.sv | 38 +++
 rtl/n64_host_poller_if.sv | 23 ++
 rtl/glitch_filter.sv | 31 +++
 rtl/n64_host_poller.sv | 164 ++++++++++++++++
 tb/tb_n64_host_poller.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64_host_poller_pkg.sv
// Shared N64 single-wire protocol constants: opcodes, reply lengths, phase
// multiples in microseconds, and the host poller state encoding.
package n64_host_poller_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [5:0] STATUS_BITS = 6'd24;
  localparam logic [5:0] POLL_BITS   = 6'd32;

  localparam int unsigned ONE_LOW_US  = 1;
  localparam int unsigned SAMPLE_US   = 2;
  localparam int unsigned ZERO_LOW_US = 3;
  localparam int unsigned BIT_US      = 4;
  localparam int unsigned STOP_LOW_US = 1;

  typedef enum logic [3:0] {
    IDLE,
    TX_LOW,
    TX_HIGH,
    TX_STOP,
    RX_WAIT,
    RX_SAMPLE,
    RX_STOP,
    DONE,
    GUARD
  } state_t;

  function automatic logic [5:0] reply_bits(input logic [7:0] cmd);
    case (cmd)
      CMD_POLL:              return POLL_BITS;
      CMD_STATUS, CMD_RESET: return STATUS_BITS;
      default:               return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/n64_host_poller_if.sv
// Command/response port of the N64 host poller; master issues commands,
// slave (the poller) executes them and reports the decoded reply.
interface n64_host_poller_if;

  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_bits;
  logic        rsp_timeout;

  modport master (
    output cmd_valid, cmd_byte,
    input  cmd_ready, rsp_valid, rsp_data, rsp_bits, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_byte,
    output cmd_ready, rsp_valid, rsp_data, rsp_bits, rsp_timeout
  );

endinterface

// File: rtl/glitch_filter.sv
// Passes a level change through only after it has been stable for STABLE
// consecutive clocks; idles high like the open-drain line it watches.
module glitch_filter #(
  parameter int STABLE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(STABLE + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(STABLE - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/n64_host_poller.sv
// Console-side N64 initiator: sends one command byte on the open-drain line
// and decodes the controller's reply into a left-aligned 32-bit word.
module n64_host_poller
  import n64_host_poller_pkg::*;
#(
  parameter int unsigned CYCLES_PER_US = 50,
  parameter int unsigned TIMEOUT_US    = 64,
  parameter int unsigned GUARD_US      = 20
) (
  input  logic             sys_clk,
  input  logic             reset,
  inout  wire              n64d,
  n64_host_poller_if.slave bus
);

  localparam logic [15:0] ONE_LOW_LAST  = 16'(ONE_LOW_US * CYCLES_PER_US - 1);
  localparam logic [15:0] ZERO_LOW_LAST = 16'(ZERO_LOW_US * CYCLES_PER_US - 1);
  localparam logic [15:0] BIT_LAST      = 16'(BIT_US * CYCLES_PER_US - 1);
  localparam logic [15:0] STOP_LOW_LAST = 16'(STOP_LOW_US * CYCLES_PER_US - 1);
  localparam logic [15:0] SAMPLE_LAST   = 16'(SAMPLE_US * CYCLES_PER_US - 1);
  localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_US * CYCLES_PER_US - 1);
  localparam logic [15:0] GUARD_LAST    = 16'(GUARD_US * CYCLES_PER_US - 1);

  state_t      state;
  logic [15:0] phase_cnt;
  logic [5:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [5:0]  rx_len;
  logic        drive_low;
  logic        stop_low;
  logic [1:0]  sync;
  logic        rx_f;
  logic        rx_f_d;
  logic        rx_fall;
  logic [15:0] low_last;

  assign n64d = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync   <= 2'b11;
      rx_f_d <= 1'b1;
    end else begin
      sync   <= {sync[0], n64d};
      rx_f_d <= rx_f;
    end
  end

  glitch_filter u_filter (
    .clk   (sys_clk),
    .reset (reset),
    .din   (sync[1]),
    .dout  (rx_f)
  );

  assign rx_fall  = rx_f_d & ~rx_f;
  assign low_last = tx_sh[7] ? ONE_LOW_LAST : ZERO_LOW_LAST;

  // phase_cnt runs through a whole TX bit so low and high phases share one count.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= '0;
      bit_cnt         <= '0;
      tx_sh           <= '0;
      rx_len          <= '0;
      drive_low       <= 1'b0;
      stop_low        <= 1'b0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_bits    <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      phase_cnt     <= phase_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (!bus.cmd_ready) begin
            if (phase_cnt == GUARD_LAST) bus.cmd_ready <= 1'b1;
          end else if (bus.cmd_valid) begin
            bus.cmd_ready   <= 1'b0;
            tx_sh           <= bus.cmd_byte;
            rx_len          <= reply_bits(bus.cmd_byte);
            bus.rsp_data    <= '0;
            bus.rsp_bits    <= '0;
            bus.rsp_timeout <= 1'b0;
            bit_cnt         <= '0;
            phase_cnt       <= '0;
            drive_low       <= 1'b1;
            state           <= TX_LOW;
          end
        end
        TX_LOW: begin
          if (phase_cnt == low_last) begin
            drive_low <= 1'b0;
            state     <= TX_HIGH;
          end
        end
        TX_HIGH: begin
          if (phase_cnt == BIT_LAST) begin
            phase_cnt <= '0;
            drive_low <= 1'b1;
            tx_sh     <= {tx_sh[6:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            state     <= (bit_cnt == 6'd7) ? TX_STOP : TX_LOW;
          end
        end
        TX_STOP: begin
          if (phase_cnt == STOP_LOW_LAST) begin
            drive_low <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            state     <= (rx_len == '0) ? DONE : RX_WAIT;
          end
        end
        RX_WAIT: begin
          if (rx_fall) begin
            phase_cnt <= '0;
            state     <= RX_SAMPLE;
          end else if (phase_cnt == TIMEOUT_LAST) begin
            bus.rsp_timeout <= 1'b1;
            state           <= DONE;
          end
        end
        RX_SAMPLE: begin
          if (phase_cnt == SAMPLE_LAST) begin
            phase_cnt <= '0;
            if (rx_f) bus.rsp_data <= bus.rsp_data | (32'h8000_0000 >> bit_cnt);
            bit_cnt      <= bit_cnt + 1'b1;
            bus.rsp_bits <= bit_cnt + 1'b1;
            stop_low     <= 1'b0;
            state        <= (bit_cnt + 6'd1 == rx_len) ? RX_STOP : RX_WAIT;
          end
        end
        RX_STOP: begin
          // Stop bit is a falling edge followed by release; either half may time out.
          if (!stop_low && rx_fall) begin
            stop_low  <= 1'b1;
            phase_cnt <= '0;
          end else if (stop_low && rx_f) begin
            state <= DONE;
          end else if (phase_cnt == TIMEOUT_LAST) begin
            bus.rsp_timeout <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.rsp_valid <= 1'b1;
          phase_cnt     <= '0;
          state         <= GUARD;
        end
        GUARD: begin
          if (phase_cnt == GUARD_LAST) begin
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_host_poller.sv
// Bench for n64_host_poller: a controller model answers on the shared line,
// expected replies go into a scoreboard queue checked by a separate monitor.
module tb_n64_host_poller;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [5:0]  bits;
    logic        timeout;
  } rsp_t;

  logic sys_clk;
  logic reset;
  logic dev_low;
  wire  n64d;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rsp_cyc = 0;
  int   rel_cyc = 0;
  rsp_t exp_q[$];

  n64_host_poller_if bus ();

  n64_host_poller dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .n64d    (n64d),
    .bus     (bus)
  );

  pullup (n64d);
  assign n64d = dev_low ? 1'b0 : 1'bz;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never seen", name);
  endtask

  task automatic push(input string tag, input logic [31:0] data, input logic [5:0] bits,
                      input logic timeout);
    rsp_t e;
    e.tag = tag; e.data = data; e.bits = bits; e.timeout = timeout;
    exp_q.push_back(e);
  endtask

  task automatic wait_line(input logic lvl, input int limit, output bit ok);
    int t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (n64d !== lvl && t < limit);
    ok = (n64d === lvl);
  endtask

  task automatic wait_ready(input int limit, output int cnt);
    cnt = 0;
    while (bus.cmd_ready !== 1'b1 && cnt < limit) begin
      @(negedge sys_clk);
      cnt++;
    end
    if (bus.cmd_ready !== 1'b1) fail("cmd_ready_wait");
  endtask

  task automatic send_cmd(input logic [7:0] b, output int acc);
    int t = 0;
    @(negedge sys_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    while (bus.cmd_ready !== 1'b1 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    acc = cyc;
    if (bus.cmd_ready !== 1'b1) fail("cmd_accept");
    @(negedge sys_clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h5A;
  endtask

  // Controller model: measures the 8 command lows plus stop, then answers.
  task automatic device(input string tag, input logic [7:0] exp_cmd, input logic [31:0] data,
                        input int n, input bit stop);
    int         w[9];
    int         bad = 0;
    logic [7:0] got = '0;
    bit         ok;
    for (int k = 0; k < 9; k++) begin
      wait_line(1'b0, 3000, ok);
      if (!ok) begin
        fail({tag, "_tx_pulse"});
        return;
      end
      w[k] = 0;
      while (n64d === 1'b0 && w[k] < 1000) begin
        @(negedge sys_clk);
        w[k]++;
      end
    end
    rel_cyc = cyc;
    for (int k = 0; k < 8; k++) begin
      if (w[k] != 50 && w[k] != 150) bad++;
      got = {got[6:0], w[k] < 100};
    end
    check({tag, "_tx_width_errs"}, 32'(bad), 32'd0);
    check({tag, "_tx_byte"}, 32'(got), 32'(exp_cmd));
    check({tag, "_tx_stop_width"}, 32'(w[8]), 32'd50);
    if (n > 0) begin
      repeat (100) @(negedge sys_clk);
      for (int i = 0; i < n; i++) begin
        int lo = data[31-i] ? 50 : 150;
        dev_low = 1'b1;
        repeat (lo) @(negedge sys_clk);
        dev_low = 1'b0;
        repeat (200 - lo) @(negedge sys_clk);
      end
      if (stop) begin
        dev_low = 1'b1;
        repeat (100) @(negedge sys_clk);
        dev_low = 1'b0;
      end
    end
  endtask

  // Monitor: every rsp_valid pulse pops one expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge sys_clk);
      if (bus.rsp_valid === 1'b1) begin
        rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid with data %0h, required no response",
                   bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_data"}, bus.rsp_data, e.data);
          check({e.tag, "_bits"}, 32'(bus.rsp_bits), 32'(e.bits));
          check({e.tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(e.timeout));
        end
      end
    end
  end

  initial begin
    int acc;
    int cnt;
    int gap;
    bit ok;
    reset = 1'b1;
    dev_low = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_line", 32'(n64d), 32'd1);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_bits", 32'(bus.rsp_bits), 32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    reset = 1'b0;
    wait_ready(3000, cnt);
    check_range("rst_guard_len", cnt, 999, 1001);

    push("poll", 32'h8040_1F7F, 6'd32, 1'b0);
    fork
      send_cmd(8'h01, acc);
      device("poll", 8'h01, 32'h8040_1F7F, 32, 1'b1);
    join
    wait_ready(5000, cnt);

    push("status", 32'h0500_0200, 6'd24, 1'b0);
    fork
      send_cmd(8'h00, acc);
      device("status", 8'h00, 32'h0500_0200, 24, 1'b1);
    join
    wait_ready(5000, cnt);

    push("noresp", 32'h0, 6'd0, 1'b1);
    fork
      send_cmd(8'h01, acc);
      device("noresp", 8'h01, 32'h0, 0, 1'b0);
    join
    wait_ready(8000, cnt);
    check_range("noresp_timeout_len", rsp_cyc - rel_cyc, 3199, 3202);

    push("partial", 32'hB340_0000, 6'd10, 1'b1);
    fork
      send_cmd(8'h01, acc);
      device("partial", 8'h01, 32'hB340_0000, 10, 1'b0);
    join
    wait_ready(8000, cnt);

    push("nostop", 32'hA5C3_3C00, 6'd24, 1'b1);
    fork
      send_cmd(8'hFF, acc);
      device("nostop", 8'hFF, 32'hA5C3_3C00, 24, 1'b0);
    join
    wait_ready(8000, cnt);

    // Reset in the middle of TX bit 4: no response is queued.
    fork
      send_cmd(8'h01, acc);
      begin
        for (int k = 0; k < 5; k++) begin
          wait_line(1'b0, 3000, ok);
          if (!ok) fail("midrst_pulse_low");
          if (k < 4) begin
            wait_line(1'b1, 1000, ok);
            if (!ok) fail("midrst_pulse_high");
          end
        end
      end
    join
    repeat (20) @(negedge sys_clk);
    check("midrst_line_before", 32'(n64d), 32'd0);
    reset = 1'b1;
    @(negedge sys_clk);
    check("midrst_line_released", 32'(n64d), 32'd1);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    check("midrst_rsp_data", bus.rsp_data, 32'd0);
    wait_ready(3000, cnt);
    check_range("midrst_guard_len", cnt, 999, 1001);

    push("loop", 32'h1234_5678, 6'd32, 1'b0);
    fork
      send_cmd(8'h01, acc);
      device("loop", 8'h01, 32'h1234_5678, 32, 1'b1);
    join
    push("b2b_unknown", 32'h0, 6'd0, 1'b0);
    gap = 0;
    fork
      begin
        send_cmd(8'hAB, acc);
        gap = acc - rsp_cyc;
      end
      device("b2b_unknown", 8'hAB, 32'h0, 0, 1'b0);
    join
    check_range("b2b_guard_gap", gap, 999, 1001);
    wait_ready(5000, cnt);

    repeat (10) @(negedge sys_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
